// File: rtl/fetch_dma_issuer_if.sv
// Valid/ready stream bundle shared by the fetch-entry input
// and the DMA read-command output of fetch_dma_issuer.
interface fetch_dma_issuer_if #(
  parameter int W = 128
);
  logic         TVALID;
  logic         TREADY;
  logic [W-1:0] TDATA;

  modport master (
    output TVALID,
    output TDATA,
    input  TREADY
  );

  modport slave (
    input  TVALID,
    input  TDATA,
    output TREADY
  );
endinterface

// File: rtl/fetch_dma_issuer.sv
// Turns SRPT fetch entries into credit-limited host DMA read commands.
// Optional counters: define FETCH_DMA_ISSUER_STATS_EN.
module fetch_dma_issuer #(
  parameter int MAX_RPCS         = 64,
  parameter int CACHE_BLOCK_SIZE = 64,
  parameter int DBUFF_SIZE_LOG2  = 14,
  parameter int TAGS             = 8,
  parameter int ENTRY_W          = 66
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  fetch_dma_issuer_if.slave       S_AXIS,
  fetch_dma_issuer_if.master      M_AXIS,
  input  logic                    tbl_wr_en,
  input  logic [15:0]             tbl_wr_rpc,
  input  logic [63:0]             tbl_wr_addr,
  input  logic                    cpl_valid,
  output logic [$clog2(TAGS):0]   credits,
  output logic                    err_cpl
`ifdef FETCH_DMA_ISSUER_STATS_EN
  ,
  output logic [31:0]             stat_cmds,
  output logic [47:0]             stat_bytes,
  output logic [31:0]             stat_stall
`endif
);

  localparam int IW = $clog2(MAX_RPCS);
  localparam int TW = $clog2(TAGS);
  localparam int CW = TW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT,
    S_ISSUE
  } state_t;

  state_t         r_state;
  logic           r_tready;
  logic           r_tvalid;
  logic [127:0]   r_tdata;
  logic [CW-1:0]  r_credits;
  logic [TW-1:0]  r_tag;
  logic           r_err;
  logic [63:0]    r_base;
  logic [9:0]     r_dbuff;
  logic [19:0]    r_rem;
  logic [19:0]    r_mlen;
  logic [19:0]    r_off;
  logic [15:0]    r_len;

  logic [63:0]    r_tbl [MAX_RPCS];

  logic [63:0]    w_host;
  logic [23:0]    w_card;
  logic [127:0]   w_cmd;
  logic           w_issue;
  logic           w_unused;

  assign w_host  = r_base + {44'b0, r_off};
  assign w_card  = 24'({r_dbuff, r_off[DBUFF_SIZE_LOG2-1:0]});
  assign w_cmd   = {{(128-104-TW){1'b0}}, r_tag, r_len, w_card, w_host};
  assign w_issue = (r_state == S_ISSUE) && M_AXIS.TREADY;
  assign w_unused = ^{tbl_wr_rpc[15:IW], S_AXIS.TDATA[15:IW]};

  assign S_AXIS.TREADY = r_tready;
  assign M_AXIS.TVALID = r_tvalid;
  assign M_AXIS.TDATA  = r_tdata;
  assign credits       = r_credits;
  assign err_cpl       = r_err;

  // Base table is intentionally unreset; the read in S_IDLE is read-first
  always_ff @(posedge ap_clk) begin
    if (tbl_wr_en) begin
      r_tbl[tbl_wr_rpc[IW-1:0]] <= tbl_wr_addr;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state   <= S_IDLE;
      r_tready  <= 1'b0;
      r_tvalid  <= 1'b0;
      r_tdata   <= '0;
      r_credits <= CW'(TAGS);
      r_tag     <= '0;
      r_err     <= 1'b0;
      r_base    <= '0;
      r_dbuff   <= '0;
      r_rem     <= '0;
      r_mlen    <= '0;
      r_off     <= '0;
      r_len     <= '0;
    end else begin
      if (w_issue && !cpl_valid) begin
        r_credits <= r_credits - 1'b1;
      end else if (cpl_valid && !w_issue) begin
        if (r_credits < CW'(TAGS)) begin
          r_credits <= r_credits + 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end

      unique case (r_state)
        S_IDLE: begin
          r_tready <= 1'b1;
          if (S_AXIS.TVALID && r_tready) begin
            r_tready <= 1'b0;
            r_dbuff  <= S_AXIS.TDATA[25:16];
            r_rem    <= S_AXIS.TDATA[45:26];
            r_mlen   <= S_AXIS.TDATA[65:46];
            r_base   <= r_tbl[S_AXIS.TDATA[IW-1:0]];
            r_state  <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_off <= r_mlen - r_rem;
          r_len <= (r_rem > 20'(CACHE_BLOCK_SIZE)) ?
                   16'(CACHE_BLOCK_SIZE) : r_rem[15:0];
          if (r_rem == '0) begin
            r_tready <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_credits != '0) begin
            r_tdata  <= w_cmd;
            r_tvalid <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (M_AXIS.TREADY) begin
            r_tvalid <= 1'b0;
            r_tag    <= r_tag + 1'b1;
            r_tready <= 1'b1;
            r_state  <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_DMA_ISSUER_STATS_EN
  logic [31:0] r_stat_cmds;
  logic [47:0] r_stat_bytes;
  logic [31:0] r_stat_stall;

  assign stat_cmds  = r_stat_cmds;
  assign stat_bytes = r_stat_bytes;
  assign stat_stall = r_stat_stall;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_stat_cmds  <= '0;
      r_stat_bytes <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_issue) begin
        r_stat_cmds  <= r_stat_cmds + 32'd1;
        r_stat_bytes <= r_stat_bytes + 48'(r_len);
      end
      if ((r_state == S_WAIT) && (r_credits == '0)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_dma_issuer.sv
// Directed bench for fetch_dma_issuer: latency, stream, credits,
// zero-length drop, completion error and reset during issue.
module tb_fetch_dma_issuer;

  logic         ap_clk = 1'b0;
  logic         ap_rst = 1'b1;
  logic         tbl_wr_en = 1'b0;
  logic [15:0]  tbl_wr_rpc = '0;
  logic [63:0]  tbl_wr_addr = '0;
  logic         cpl_valid = 1'b0;
  logic [3:0]   credits;
  logic         err_cpl;
`ifdef FETCH_DMA_ISSUER_STATS_EN
  logic [31:0]  stat_cmds;
  logic [47:0]  stat_bytes;
  logic [31:0]  stat_stall;
`endif

  fetch_dma_issuer_if #(.W(66))  s_if ();
  fetch_dma_issuer_if #(.W(128)) m_if ();

  fetch_dma_issuer dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .S_AXIS      (s_if.slave),
    .M_AXIS      (m_if.master),
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_rpc  (tbl_wr_rpc),
    .tbl_wr_addr (tbl_wr_addr),
    .cpl_valid   (cpl_valid),
    .credits     (credits),
    .err_cpl     (err_cpl)
`ifdef FETCH_DMA_ISSUER_STATS_EN
    ,
    .stat_cmds   (stat_cmds),
    .stat_bytes  (stat_bytes),
    .stat_stall  (stat_stall)
`endif
  );

  always #5 ap_clk = ~ap_clk;

  int           n_chk  = 0;
  int           n_fail = 0;
  logic [2:0]   exp_tag = '0;
  logic [127:0] last_cmd = '0;

  function automatic logic [127:0] mk(logic [63:0] h, logic [23:0] c,
                                      logic [15:0] l, logic [2:0] t);
    logic [127:0] v;
    v = 128'(h);
    v = v | (128'(c) << 64);
    v = v | (128'(l) << 88);
    v = v | (128'(t) << 104);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge right after the accept edge
  task automatic send(input logic [15:0] rpc, input logic [9:0] dbuff,
                      input logic [19:0] rem, input logic [19:0] mlen);
    int i;
    s_if.TDATA  = {mlen, rem, dbuff, rpc};
    s_if.TVALID = 1'b1;
    i = 0;
    while (!s_if.TREADY && i < 20) begin
      @(negedge ap_clk);
      i++;
    end
    chk("accept", 128'(s_if.TREADY), 128'd1);
    @(negedge ap_clk);
    s_if.TVALID = 1'b0;
  endtask

  // Waits for a command, checks it, lets it handshake, optionally completes it
  task automatic take(input logic [127:0] exp, input bit do_cpl,
                      input string tag);
    for (int i = 0; i < 12 && !m_if.TVALID; i++) @(negedge ap_clk);
    chk({tag, "_valid"}, 128'(m_if.TVALID), 128'd1);
    chk(tag, m_if.TDATA, exp);
    last_cmd = m_if.TDATA;
    @(negedge ap_clk);
    exp_tag = exp_tag + 3'd1;
    if (do_cpl) begin
      cpl_valid = 1'b1;
      @(negedge ap_clk);
      cpl_valid = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] rem;
    logic [19:0] off;
    logic [15:0] len;
    bit          saw;

    s_if.TVALID = 1'b0;
    s_if.TDATA  = '0;
    m_if.TREADY = 1'b1;

    // Reset state; table loads while in reset since it is unreset storage
    tbl_wr_en   = 1'b1;
    tbl_wr_rpc  = 16'd1;
    tbl_wr_addr = 64'h0000_0000_1000_0000;
    @(negedge ap_clk);
    tbl_wr_en = 1'b0;
    @(negedge ap_clk);
    chk("rst_tready", 128'(s_if.TREADY), 128'd0);
    chk("rst_tvalid", 128'(m_if.TVALID), 128'd0);
    chk("rst_tdata", m_if.TDATA, 128'd0);
    chk("rst_credits", 128'(credits), 128'd8);
    chk("rst_err", 128'(err_cpl), 128'd0);
    ap_rst = 1'b0;

    // First command: two-cycle latency
    send(16'd1, 10'd0, 20'd10000, 20'd10000);
    chk("lat_n0", 128'(m_if.TVALID), 128'd0);
    @(negedge ap_clk);
    chk("lat_n1", 128'(m_if.TVALID), 128'd0);
    @(negedge ap_clk);
    chk("lat_n2", 128'(m_if.TVALID), 128'd1);
    take(mk(64'h1000_0000, 24'd0, 16'd64, 3'd0), 1'b1, "first");
    chk("first_credits", 128'(credits), 128'd8);

    // 157-entry stream for a 10000-byte message with prompt completions
    for (int k = 0; k < 157; k++) begin
      rem = 20'(10000 - 64 * k);
      off = 20'(64 * k);
      len = (rem > 20'd64) ? 16'd64 : rem[15:0];
      send(16'd1, 10'd5, rem, 20'd10000);
      take(mk(64'h1000_0000 + 64'(off), 24'(5 * 16384) + 24'(off),
              len, exp_tag), 1'b1, "stream");
      chk("stream_credits", 128'(credits), 128'd8);
    end
    chk("last_len", 128'(last_cmd[103:88]), 128'd16);
    chk("last_host", 128'(last_cmd[63:0]), 128'h1000_2700);

    // No completions: host address wraps, 9th entry stalls
    @(negedge ap_clk);
    tbl_wr_en   = 1'b1;
    tbl_wr_rpc  = 16'd2;
    tbl_wr_addr = 64'hFFFF_FFFF_FFFF_FFF0;
    @(negedge ap_clk);
    tbl_wr_en = 1'b0;
    for (int j = 0; j < 8; j++) begin
      send(16'd2, 10'h3FF, 20'd36, 20'd100);
      take(mk(64'h30, 24'hFFC040, 16'd36, exp_tag), 1'b0, "nocpl");
    end
    chk("drained_credits", 128'(credits), 128'd0);
    send(16'd2, 10'h3FF, 20'd36, 20'd100);
    repeat (4) @(negedge ap_clk);
    chk("stall_tvalid", 128'(m_if.TVALID), 128'd0);
    chk("stall_credits", 128'(credits), 128'd0);
    chk("stall_tready", 128'(s_if.TREADY), 128'd0);
    cpl_valid = 1'b1;
    @(negedge ap_clk);
    cpl_valid = 1'b0;
    @(negedge ap_clk);
    chk("release_tvalid", 128'(m_if.TVALID), 128'd1);
    take(mk(64'h30, 24'hFFC040, 16'd36, exp_tag), 1'b0, "released");
    chk("released_credits", 128'(credits), 128'd0);
    cpl_valid = 1'b1;
    repeat (8) @(negedge ap_clk);
    cpl_valid = 1'b0;
    chk("refill_credits", 128'(credits), 128'd8);
    chk("refill_err", 128'(err_cpl), 128'd0);

    // Table write on the accept edge: read returns the old base
    chk("rf_tready", 128'(s_if.TREADY), 128'd1);
    tbl_wr_en   = 1'b1;
    tbl_wr_rpc  = 16'd2;
    tbl_wr_addr = 64'h2000_0000_0000_0000;
    send(16'd2, 10'd1, 20'd50, 20'd50);
    tbl_wr_en = 1'b0;
    take(mk(64'hFFFF_FFFF_FFFF_FFF0, 24'h4000, 16'd50, exp_tag),
         1'b1, "readfirst");
    send(16'd2, 10'd1, 20'd50, 20'd50);
    take(mk(64'h2000_0000_0000_0000, 24'h4000, 16'd50, exp_tag),
         1'b1, "newbase");

    // Zero remaining bytes: entry is dropped
    send(16'd1, 10'd0, 20'd0, 20'd500);
    saw = 1'b0;
    repeat (6) begin
      if (m_if.TVALID) saw = 1'b1;
      @(negedge ap_clk);
    end
    chk("zero_novalid", 128'(saw), 128'd0);
    chk("zero_credits", 128'(credits), 128'd8);
    chk("zero_tready", 128'(s_if.TREADY), 128'd1);

    // Completion with nothing outstanding
    cpl_valid = 1'b1;
    @(negedge ap_clk);
    cpl_valid = 1'b0;
    chk("err_set", 128'(err_cpl), 128'd1);
    chk("err_credits", 128'(credits), 128'd8);

    // Reset while a command is held in ISSUE
    send(16'd1, 10'd2, 20'd64, 20'd64);
    take(mk(64'h1000_0000, 24'h8000, 16'd64, exp_tag), 1'b0, "pre_rst");
    chk("pre_rst_credits", 128'(credits), 128'd7);
    m_if.TREADY = 1'b0;
    send(16'd1, 10'd3, 20'd200, 20'd1000);
    for (int i = 0; i < 12 && !m_if.TVALID; i++) @(negedge ap_clk);
    chk("hold_a", m_if.TDATA,
        mk(64'h1000_0320, 24'hC320, 16'd64, exp_tag));
    repeat (3) @(negedge ap_clk);
    chk("hold_valid", 128'(m_if.TVALID), 128'd1);
    chk("hold_b", m_if.TDATA,
        mk(64'h1000_0320, 24'hC320, 16'd64, exp_tag));
    ap_rst = 1'b1;
    #1;
    chk("mid_rst_tvalid", 128'(m_if.TVALID), 128'd0);
    chk("mid_rst_tdata", m_if.TDATA, 128'd0);
    chk("mid_rst_credits", 128'(credits), 128'd8);
    chk("mid_rst_err", 128'(err_cpl), 128'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    m_if.TREADY = 1'b1;
    exp_tag = 3'd0;
    send(16'd1, 10'd3, 20'd200, 20'd1000);
    take(mk(64'h1000_0320, 24'hC320, 16'd64, exp_tag), 1'b1, "post_rst");
    chk("post_rst_credits", 128'(credits), 128'd8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
